alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter: two requesters share one external gate-level ALU.
// Latency: result valid SETTLE cycles after accept; one command per SETTLE+2 cycles.
// Backpressure: readys stay low until the result is taken with res_valid & res_ready.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carryout,
    output logic             res_overflow,
    output logic             res_zero,
    output logic             res_id,
    output logic             busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_zero_q, res_zero_d;
    logic             res_id_q, res_id_d;

    logic gnt0, gnt1, flag_en;

    // last_q holds the id served most recently; a tie goes to the other one.
    always_comb begin
        gnt0 = rst_n && (state_q == ST_IDLE) && req0_valid && (!req1_valid || last_q);
        gnt1 = rst_n && (state_q == ST_IDLE) && req1_valid && (!req0_valid || !last_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_ovf_d   = res_ovf_q;
        res_zero_d  = res_zero_q;
        res_id_d    = res_id_q;
        flag_en     = (alu_op_q == OP_ADD) || (alu_op_q == OP_SUB);
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    alu_op_d = gnt1 ? req1_op : req0_op;
                    alu_a_d  = gnt1 ? req1_a  : req0_a;
                    alu_b_d  = gnt1 ? req1_b  : req0_b;
                    cnt_d    = CNT_INIT;
                    last_d   = gnt1;
                    res_id_d = gnt1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_data_d  = alu_result;
                    res_zero_d  = alu_zero;
                    res_carry_d = flag_en && alu_carryout;
                    res_ovf_d   = flag_en && alu_overflow;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            last_q      <= 1'b1;
            alu_op_q    <= 3'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_ovf_q   <= res_ovf_d;
            res_zero_q  <= res_zero_d;
            res_id_q    <= res_id_d;
        end
    end

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign alu_op       = alu_op_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_carryout = res_carry_q;
    assign res_overflow = res_ovf_q;
    assign res_zero     = res_zero_q;
    assign res_id       = res_id_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]   req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
    logic [W-1:0] alu_result, res_data;
    logic         alu_carryout, alu_overflow, alu_zero;
    logic         res_valid, res_ready, res_carryout, res_overflow, res_zero, res_id, busy;
    logic         force_flags;
    logic [W:0]   sum;

    int tests = 0;
    int fails = 0;

    alu_arbiter #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carryout(res_carryout), .res_overflow(res_overflow),
        .res_zero(res_zero), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared ALU; force_flags makes the logic ops raise carry/overflow too.
    always_comb begin
        sum          = '0;
        alu_result   = '0;
        alu_carryout = force_flags;
        alu_overflow = force_flags;
        case (alu_op)
            3'd0: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = sum[W-1:0];
                alu_carryout = sum[W];
                alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'd1: begin
                sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result   = sum[W-1:0];
                alu_carryout = sum[W];
                alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'd2: alu_result = alu_a ^ alu_b;
            3'd3: alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            3'd4: alu_result = alu_a & alu_b;
            3'd5: alu_result = ~(alu_a & alu_b);
            3'd6: alu_result = ~(alu_a | alu_b);
            default: alu_result = alu_a | alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_res();
        repeat (ST - 1) step();
        chk("valid_not_early", 32'(res_valid), 32'd0);
        step();
        chk("valid_on_time", 32'(res_valid), 32'd1);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("drain_valid", 32'(res_valid), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; res_ready = 1'b0; force_flags = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 3'd0; req0_a = '0; req0_b = '0;
        req1_op = 3'd0; req1_a = '0; req1_b = '0;
        @(negedge clk);
        // Reset state
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // req0 ADD 5+7 alone
        req0_op = 3'd0; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        #1;
        chk("a_rdy0", 32'(req0_ready), 32'd1);
        chk("a_rdy1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_alu_a", alu_a, 32'd5);
        chk("a_alu_b", alu_b, 32'd7);
        wait_res();
        chk("a_data", res_data, 32'd12);
        chk("a_id", 32'(res_id), 32'd0);
        chk("a_co", 32'(res_carryout), 32'd0);
        chk("a_ov", 32'(res_overflow), 32'd0);
        chk("a_z", 32'(res_zero), 32'd0);
        drain();

        // req1 SUB 0x80000000-1 overflows
        req1_op = 3'd1; req1_a = 32'h8000_0000; req1_b = 32'd1; req1_valid = 1'b1;
        #1;
        chk("b_rdy1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        wait_res();
        chk("b_data", res_data, 32'h7FFF_FFFF);
        chk("b_ov", 32'(res_overflow), 32'd1);
        chk("b_co", 32'(res_carryout), 32'd1);
        chk("b_id", 32'(res_id), 32'd1);
        drain();

        // Both valid continuously: grants alternate 0,1,0,1
        req0_op = 3'd2; req0_a = 32'hFF;  req0_b = 32'h0F;
        req1_op = 3'd7; req1_a = 32'h100; req1_b = 32'h1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("d_rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("d_rdy1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            chk("d_alu_op", 32'(alu_op), (i % 2 == 0) ? 32'd2 : 32'd7);
            chk("d_rdy_low", 32'(req0_ready | req1_ready), 32'd0);
            wait_res();
            chk("d_id", 32'(res_id), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("d_data", res_data, (i % 2 == 0) ? 32'hF0 : 32'h101);
            drain();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // AND with ALU flags forced high: flags masked, zero set
        force_flags = 1'b1;
        req0_op = 3'd4; req0_a = 32'hF0; req0_b = 32'h0F; req0_valid = 1'b1;
        #1;
        chk("c_rdy0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        wait_res();
        chk("c_data", res_data, 32'd0);
        chk("c_z", 32'(res_zero), 32'd1);
        chk("c_co", 32'(res_carryout), 32'd0);
        chk("c_ov", 32'(res_overflow), 32'd0);
        drain();
        force_flags = 1'b0;

        // Held DONE with both valid; last served was 0 so req1 wins the tie
        req0_op = 3'd5; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
        req1_op = 3'd3; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("e_rdy1", 32'(req1_ready), 32'd1);
        chk("e_rdy0", 32'(req0_ready), 32'd0);
        step();
        wait_res();
        chk("e_data", res_data, 32'd1);
        chk("e_id", 32'(res_id), 32'd1);
        repeat (10) begin
            step();
            chk("e_hold_valid", 32'(res_valid), 32'd1);
            chk("e_hold_data", res_data, 32'd1);
            chk("e_hold_id", 32'(res_id), 32'd1);
            chk("e_hold_rdy", 32'(req0_ready | req1_ready), 32'd0);
            chk("e_hold_busy", 32'(busy), 32'd1);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("e_hs_valid", 32'(res_valid), 32'd0);
        chk("e_hs_busy", 32'(busy), 32'd0);
        chk("e_next_rdy0", 32'(req0_ready), 32'd1);
        chk("e_next_rdy1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("e_next_busy", 32'(busy), 32'd1);
        chk("e_next_op", 32'(alu_op), 32'd5);
        wait_res();
        chk("e_nand_data", res_data, 32'd0);
        chk("e_nand_z", 32'(res_zero), 32'd1);
        chk("e_nand_id", 32'(res_id), 32'd0);
        drain();

        // Reset mid-SETTLE aborts; pointer returns to favour req0
        req0_op = 3'd0; req0_a = 32'h11; req0_b = 32'h22; req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        chk("f_alu_a", alu_a, 32'h11);
        step();
        rst_n = 1'b0;
        #1;
        chk("f_rst_valid", 32'(res_valid), 32'd0);
        chk("f_rst_alu_a", alu_a, 32'd0);
        chk("f_rst_busy", 32'(busy), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_op = 3'd0; req1_a = 32'h33; req1_b = 32'h0;
        step();
        chk("f_rst_rdy", 32'(req0_ready | req1_ready), 32'd0);
        step();
        chk("f_rst_valid2", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("f_tie_rdy0", 32'(req0_ready), 32'd1);
        chk("f_tie_rdy1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("f_alu_a2", alu_a, 32'h11);
        wait_res();
        chk("f_data", res_data, 32'h33);
        chk("f_id", 32'(res_id), 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
